// File: rtl/mem_access_unit.sv
// Load/store front end for a word-wide, byte-addressed data memory with combinational read.
// Sub-word stores use read-modify-write; loads are lane-extracted and sign/zero-extended.
module mem_access_unit #(
   parameter int unsigned MEM_BYTES = 65536
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wr,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [31:0] resp_rdata,
   output logic        mem_enable,
   output logic        mem_wr,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_data_in,
   input  logic [31:0] mem_data_out
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      RMW_RD = 3'd2,
      STORE  = 3'd3,
      RESP   = 3'd4
   } state_t;

   state_t      state;
   logic        wr_q;
   logic [1:0]  size_q;
   logic        signed_q;
   logic        err_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] merge_q;
   logic [31:0] rdata_q;
   logic        mem_active;

   function automatic logic bad_req(input logic [1:0] size, input logic [31:0] addr);
      return (size == 2'b11) ||
             (size == 2'b01 && addr[0]) ||
             (size == 2'b10 && addr[1:0] != 2'b00) ||
             ({addr[31:2], 2'b00} >= MEM_BYTES);
   endfunction

   function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                           input logic [1:0] lo, input logic sgn);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{lo, 3'b000} +: 8];
      h = word[{lo[1], 4'b0000} +: 16];
      case (size)
         2'b00:   return {{24{sgn & b[7]}}, b};
         2'b01:   return {{16{sgn & h[15]}}, h};
         default: return word;
      endcase
   endfunction

   function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [15:0] wd,
                                              input logic [1:0] size, input logic [1:0] lo);
      logic [31:0] m;
      m = word;
      if (size == 2'b00) m[{lo, 3'b000} +: 8] = wd[7:0];
      else               m[{lo[1], 4'b0000} +: 16] = wd;
      return m;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         wr_q     <= 1'b0;
         size_q   <= 2'b00;
         signed_q <= 1'b0;
         err_q    <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         merge_q  <= '0;
         rdata_q  <= '0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               wr_q     <= req_wr;
               size_q   <= req_size;
               signed_q <= req_signed;
               addr_q   <= req_addr;
               wdata_q  <= req_wdata;
               rdata_q  <= '0;
               if (bad_req(req_size, req_addr)) begin
                  err_q <= 1'b1;
                  state <= RESP;
               end else begin
                  err_q <= 1'b0;
                  if (!req_wr)               state <= LOAD;
                  else if (req_size == 2'b10) state <= STORE;
                  else                       state <= RMW_RD;
               end
            end
            LOAD: begin
               rdata_q <= extract(mem_data_out, size_q, addr_q[1:0], signed_q);
               state   <= RESP;
            end
            RMW_RD: begin
               merge_q <= merge_lane(mem_data_out, wdata_q[15:0], size_q, addr_q[1:0]);
               state   <= STORE;
            end
            STORE:   state <= RESP;
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Outputs decode from registers only, so an async reset clears them at once.
   always_comb begin
      mem_active  = (state == LOAD) || (state == RMW_RD) || (state == STORE);
      req_ready   = (state == IDLE);
      resp_valid  = (state == RESP);
      resp_err    = resp_valid & err_q;
      resp_rdata  = resp_valid ? rdata_q : '0;
      mem_enable  = mem_active;
      mem_wr      = (state == STORE);
      mem_addr    = mem_active ? {addr_q[31:2], 2'b00} : '0;
      mem_data_in = '0;
      if (state == STORE) mem_data_in = (size_q == 2'b10) ? wdata_q : merge_q;
   end

   logic unused_ok;
   assign unused_ok = wr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: word-array memory, request-level reference model and
// a per-cycle comparison of every DUT output against that model.
module tb_mem_access_unit;
   localparam int unsigned MEM_BYTES = 65536;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_wr = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_signed = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic        mem_enable;
   logic        mem_wr;
   logic [31:0] mem_addr;
   logic [31:0] mem_data_in;
   logic [31:0] mem_data_out;

   mem_access_unit #(.MEM_BYTES(MEM_BYTES)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
      .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
      .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
   );

   always #5 clk = ~clk;

   logic [31:0] mem    [0:16383];
   logic [31:0] shadow [0:16383];
   assign mem_data_out = mem[mem_addr[15:2]];

   int checks = 0;
   int errors = 0;
   int edge_n = 0;
   int acc_cnt = 0;
   int rsp_cnt = 0;
   int dropped = 0;
   logic init_done = 1'b0;

   // Model record of the most recently accepted request.
   logic        cur_valid = 1'b0;
   int          cur_id = 0, cur_t = 0, cur_lat = 0, cur_kind = 0;
   logic        cur_err = 1'b0;
   logic [31:0] cur_rdata = '0, cur_base = '0, cur_wword = '0;

   int          lit_id = -1;
   logic        lit_err = 1'b0;
   logic [31:0] lit_rdata = '0;
   logic        final_chk = 1'b0;

   // Memory plus reference model; kind 0 error, 1 load, 2 word store, 3 sub-word store.
   always @(posedge clk) begin
      logic [31:0] a, base, word, mask, lane;
      int sh;
      edge_n = edge_n + 1;
      if (!init_done) begin
         for (int i = 0; i < 16384; i++) begin
            mem[i] <= '0;
            shadow[i] = '0;
         end
         init_done = 1'b1;
      end else if (mem_enable && mem_wr) begin
         mem[mem_addr[15:2]] <= mem_data_in;
      end
      if (!rst) begin
         if (cur_valid && edge_n < cur_t + cur_lat) dropped = dropped + 1;
         cur_valid = 1'b0;
      end else begin
         if (cur_valid && cur_kind >= 2 && edge_n == cur_t + cur_lat - 1)
            shadow[cur_base[15:2]] = cur_wword;
         if (req_valid && (!cur_valid || edge_n - 1 >= cur_t + cur_lat)) begin
            a = req_addr;
            base = {a[31:2], 2'b00};
            acc_cnt = acc_cnt + 1;
            cur_id = acc_cnt;
            cur_valid = 1'b1;
            cur_t = edge_n;
            cur_base = base;
            cur_rdata = '0;
            cur_wword = '0;
            cur_err = (req_size == 2'd3) || (req_size == 2'd1 && a[0]) ||
                      (req_size == 2'd2 && a[1:0] != 2'd0) || (base >= MEM_BYTES);
            if (cur_err) begin
               cur_kind = 0;
               cur_lat = 1;
            end else begin
               word = shadow[base[15:2]];
               if (req_size == 2'd0) begin
                  sh = 8 * int'(a[1:0]);
                  mask = 32'h0000_00FF << sh;
               end else if (req_size == 2'd1) begin
                  sh = 16 * int'(a[1]);
                  mask = 32'h0000_FFFF << sh;
               end else begin
                  sh = 0;
                  mask = 32'hFFFF_FFFF;
               end
               if (!req_wr) begin
                  cur_kind = 1;
                  cur_lat = 2;
                  lane = (word & mask) >> sh;
                  if (req_signed && req_size == 2'd0 && lane[7])  lane = lane | 32'hFFFF_FF00;
                  if (req_signed && req_size == 2'd1 && lane[15]) lane = lane | 32'hFFFF_0000;
                  cur_rdata = lane;
               end else begin
                  cur_kind = (req_size == 2'd2) ? 2 : 3;
                  cur_lat = (req_size == 2'd2) ? 2 : 3;
                  cur_wword = (word & ~mask) | ((req_wdata << sh) & mask);
               end
            end
         end
      end
   end

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s actual=0x%08h required=0x%08h edge=%0d", name, act, exp, edge_n);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s actual=%0b required=%0b edge=%0d", name, act, exp, edge_n);
      end
   endtask

   // Single compare process, sampling on the falling edge.
   always @(negedge clk) begin
      int d;
      logic due, en_e, wr_e;
      if (!rst) begin
         chk1("rst_req_ready", req_ready, 1'b1);
         chk1("rst_resp_valid", resp_valid, 1'b0);
         chk1("rst_resp_err", resp_err, 1'b0);
         chk32("rst_resp_rdata", resp_rdata, 32'h0);
         chk1("rst_mem_enable", mem_enable, 1'b0);
         chk1("rst_mem_wr", mem_wr, 1'b0);
         chk32("rst_mem_addr", mem_addr, 32'h0);
         chk32("rst_mem_data_in", mem_data_in, 32'h0);
      end else begin
         due = cur_valid && (edge_n == cur_t + cur_lat - 1);
         chk1("req_ready", req_ready, !(cur_valid && edge_n < cur_t + cur_lat));
         chk1("resp_valid", resp_valid, due);
         if (due) begin
            rsp_cnt = rsp_cnt + 1;
            chk1("resp_err", resp_err, cur_err);
            chk32("resp_rdata", resp_rdata, cur_rdata);
            if (cur_id == lit_id) begin
               chk1("lit_resp_err", resp_err, lit_err);
               chk32("lit_resp_rdata", resp_rdata, lit_rdata);
            end
         end
         d = edge_n - cur_t;
         en_e = cur_valid && ((cur_kind != 0 && d == 0) || (cur_kind == 3 && d == 1));
         wr_e = cur_valid && ((cur_kind == 2 && d == 0) || (cur_kind == 3 && d == 1));
         chk1("mem_enable", mem_enable, en_e);
         chk1("mem_wr", mem_wr, wr_e);
         chk32("mem_addr", mem_addr, en_e ? cur_base : 32'h0);
         if (wr_e)       chk32("mem_data_in", mem_data_in, cur_wword);
         else if (!en_e) chk32("mem_data_in_idle", mem_data_in, 32'h0);
      end
      if (final_chk) chk32("resp_count", rsp_cnt + dropped, acc_cnt);
   end

   task automatic do_req(input logic w, input logic [1:0] s, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic use_lit, input logic le, input logic [31:0] lr,
                         input logic hold);
      int c0;
      @(posedge clk);
      #1;
      c0 = acc_cnt;
      lit_id = use_lit ? c0 + 1 : -1;
      lit_err = le;
      lit_rdata = lr;
      req_valid = 1'b1;
      req_wr = w;
      req_size = s;
      req_signed = sg;
      req_addr = a;
      req_wdata = wd;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (acc_cnt != c0) break;
      end
      if (hold) begin
         for (int i = 0; i < 2; i++) begin
            req_wr = 1'($urandom_range(0, 1));
            req_size = 2'($urandom_range(0, 3));
            req_addr = 32'($urandom_range(0, 255));
            req_wdata = $urandom;
            @(posedge clk);
            #1;
         end
      end
      req_valid = 1'b0;
      repeat (4) @(posedge clk);
   endtask

   initial begin
      int c0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;

      do_req(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0, 1'b0);
      do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0);
      do_req(1'b1, 2'd0, 1'b0, 32'h101, 32'h000000A5, 1'b1, 1'b0, 32'h0, 1'b0);
      do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 32'hDEADA5EF, 1'b0);
      do_req(1'b0, 2'd0, 1'b1, 32'h101, 32'h0, 1'b1, 1'b0, 32'hFFFFFFA5, 1'b0);
      do_req(1'b0, 2'd0, 1'b0, 32'h101, 32'h0, 1'b1, 1'b0, 32'h000000A5, 1'b0);
      do_req(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 1'b1, 1'b0, 32'hFFFFDEAD, 1'b0);
      do_req(1'b0, 2'd1, 1'b0, 32'h103, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0);
      do_req(1'b1, 2'd2, 1'b0, 32'h102, 32'h12345678, 1'b1, 1'b1, 32'h0, 1'b0);
      do_req(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0);
      do_req(1'b0, 2'd2, 1'b0, 32'h10000, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0);

      // Busy sub-word store with req_valid held and inputs changing.
      do_req(1'b1, 2'd1, 1'b0, 32'h106, 32'h1234BEEF, 1'b0, 1'b0, 32'h0, 1'b1);
      do_req(1'b0, 2'd2, 1'b0, 32'h104, 32'h0, 1'b1, 1'b0, 32'hBEEF0000, 1'b0);

      // Reset during the read phase of a byte store.
      do_req(1'b1, 2'd2, 1'b0, 32'h200, 32'h11223344, 1'b0, 1'b0, 32'h0, 1'b0);
      @(posedge clk);
      #1;
      c0 = acc_cnt;
      req_valid = 1'b1;
      req_wr = 1'b1;
      req_size = 2'd0;
      req_signed = 1'b0;
      req_addr = 32'h201;
      req_wdata = 32'h000000EE;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (acc_cnt != c0) break;
      end
      #1;
      rst = 1'b0;
      req_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      do_req(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 1'b1, 1'b0, 32'h11223344, 1'b0);
      lit_id = -1;

      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #1;
         req_valid = 1'($urandom_range(0, 1));
         req_wr = 1'($urandom_range(0, 1));
         req_size = 2'($urandom_range(0, 3));
         req_signed = 1'($urandom_range(0, 1));
         req_wdata = $urandom;
         case ($urandom_range(0, 15))
            0:       req_addr = $urandom;
            1:       req_addr = 32'(MEM_BYTES - 8 + $urandom_range(0, 15));
            default: req_addr = 32'($urandom_range(0, 63));
         endcase
      end
      req_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1 final_chk = 1'b1;
      @(negedge clk);
      #1 final_chk = 1'b0;
      @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
